// File: rtl/chan_fifo_pkg.sv
// Shared constants and elaboration helpers for the channel FIFO bank.
package chan_fifo_pkg;

    localparam int unsigned CHAN_W = 7;
    localparam int unsigned DATA_W = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Low bit of channel k's occupancy slice in a flattened depth bus.
    function automatic int unsigned depthLo(input int unsigned k, input int unsigned depthLog2);
        return k * (depthLog2 + 1);
    endfunction

    function automatic int unsigned depthHi(input int unsigned k, input int unsigned depthLog2);
        return depthLo(k, depthLog2) + depthLog2;
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module chan_fifo
    import chan_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [DATA_W-1:0]     pushData_in,
    input  logic                  pushValid_in,
    output logic                  pushReady_out,
    output logic [DATA_W-1:0]     popData_out,
    output logic                  popValid_out,
    input  logic                  popReady_in,
    output logic [DEPTH_LOG2:0]   count_out
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop;

    // Full refuses a push even when a pop frees a slot on the same edge.
    assign pushReady_out = (count != CNT_W'(DEPTH));
    assign popValid_out  = (count != '0);
    assign popData_out   = mem[rdPtr];
    assign count_out     = count;
    assign push          = pushValid_in && pushReady_out;
    assign pop           = popValid_out && popReady_in;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wrPtr] <= pushData_in;
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + DEPTH_LOG2'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/chan_fifo_bank.sv
// Bank of host<->app channel FIFO pairs with host address decode.
// Optional host-readable occupancy channels are enabled by defining CHAN_STATUS_EN.
module chan_fifo_bank
    import chan_fifo_pkg::*;
#(
    parameter int unsigned NUM_CHAN    = 4,
    parameter int unsigned DEPTH_LOG2  = 4,
    parameter int unsigned BASE_CHAN   = 0,
    parameter int unsigned STATUS_CHAN = 64
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic [CHAN_W-1:0]                    chanAddr_in,
    input  logic [DATA_W-1:0]                    h2fData_in,
    input  logic                                 h2fValid_in,
    output logic                                 h2fReady_out,
    output logic [DATA_W-1:0]                    f2hData_out,
    output logic                                 f2hValid_out,
    input  logic                                 f2hReady_in,
    output logic [DATA_W*NUM_CHAN-1:0]           wrData_out,
    output logic [NUM_CHAN-1:0]                  wrValid_out,
    input  logic [NUM_CHAN-1:0]                  wrReady_in,
    input  logic [DATA_W*NUM_CHAN-1:0]           rdData_in,
    input  logic [NUM_CHAN-1:0]                  rdValid_in,
    output logic [NUM_CHAN-1:0]                  rdReady_out,
    output logic [NUM_CHAN*(DEPTH_LOG2+1)-1:0]   wrDepth_out,
    output logic [NUM_CHAN*(DEPTH_LOG2+1)-1:0]   rdDepth_out
);

    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned IDX_W = (NUM_CHAN > 1) ? clog2(NUM_CHAN) : 1;

    if ((BASE_CHAN + NUM_CHAN > 128) || (STATUS_CHAN + 2 * NUM_CHAN > 128)) begin : gRangeErr
        $error("chan_fifo_bank: channel range exceeds address 127");
    end
    if ((BASE_CHAN < STATUS_CHAN + 2 * NUM_CHAN) && (STATUS_CHAN < BASE_CHAN + NUM_CHAN))
    begin : gOverlapErr
        $error("chan_fifo_bank: data channels overlap status channels");
    end

    logic [NUM_CHAN-1:0][DATA_W-1:0] f2hHead;
    logic [NUM_CHAN-1:0][CNT_W-1:0]  h2fCount;
    logic [NUM_CHAN-1:0][CNT_W-1:0]  f2hCount;
    logic [NUM_CHAN-1:0]             h2fReady;
    logic [NUM_CHAN-1:0]             f2hValid;
    logic [NUM_CHAN-1:0]             h2fPush;
    logic [NUM_CHAN-1:0]             f2hPop;

    for (genvar k = 0; k < NUM_CHAN; k++) begin : gChan
        chan_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) uH2f (
            .clk_in        (clk_in),
            .reset_in      (reset_in),
            .pushData_in   (h2fData_in),
            .pushValid_in  (h2fPush[k]),
            .pushReady_out (h2fReady[k]),
            .popData_out   (wrData_out[DATA_W*k +: DATA_W]),
            .popValid_out  (wrValid_out[k]),
            .popReady_in   (wrReady_in[k]),
            .count_out     (h2fCount[k])
        );
        chan_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) uF2h (
            .clk_in        (clk_in),
            .reset_in      (reset_in),
            .pushData_in   (rdData_in[DATA_W*k +: DATA_W]),
            .pushValid_in  (rdValid_in[k]),
            .pushReady_out (rdReady_out[k]),
            .popData_out   (f2hHead[k]),
            .popValid_out  (f2hValid[k]),
            .popReady_in   (f2hPop[k]),
            .count_out     (f2hCount[k])
        );
        assign wrDepth_out[depthHi(k, DEPTH_LOG2):depthLo(k, DEPTH_LOG2)] = h2fCount[k];
        assign rdDepth_out[depthHi(k, DEPTH_LOG2):depthLo(k, DEPTH_LOG2)] = f2hCount[k];
    end

    int               dataOff;
    logic             dataHit;
    logic [IDX_W-1:0] dataIdx;

    always_comb begin
        dataOff = int'(chanAddr_in) - int'(BASE_CHAN);
        dataHit = (dataOff >= 0) && (dataOff < int'(NUM_CHAN));
        dataIdx = IDX_W'(dataOff);
    end

`ifdef CHAN_STATUS_EN
    int               statOff;
    logic             statHit;
    logic [IDX_W-1:0] statIdx;
    logic [DATA_W-1:0] statData;

    // Even offsets report the h2f count, odd offsets the f2h count.
    always_comb begin
        statOff  = int'(chanAddr_in) - int'(STATUS_CHAN);
        statHit  = (statOff >= 0) && (statOff < int'(2 * NUM_CHAN));
        statIdx  = IDX_W'(statOff >>> 1);
        statData = statOff[0] ? DATA_W'(f2hCount[statIdx]) : DATA_W'(h2fCount[statIdx]);
    end
`else
    logic              statHit;
    logic [DATA_W-1:0] statData;

    assign statHit  = 1'b0;
    assign statData = '0;
`endif

    // Unmapped and status addresses swallow writes and always offer read data.
    always_comb begin
        h2fReady_out = 1'b1;
        f2hValid_out = 1'b1;
        f2hData_out  = '0;
        h2fPush      = '0;
        f2hPop       = '0;
        if (dataHit) begin
            h2fReady_out     = h2fReady[dataIdx];
            h2fPush[dataIdx] = h2fValid_in;
            f2hValid_out     = f2hValid[dataIdx];
            f2hData_out      = f2hHead[dataIdx];
            f2hPop[dataIdx]  = f2hReady_in;
        end else if (statHit) begin
            f2hData_out = statData;
        end
    end

endmodule

// File: tb/tb_chan_fifo_bank.sv
// Self-checking bench for chan_fifo_bank against a queue-based reference model.
module tb_chan_fifo_bank;

    localparam int NUM_CHAN    = 4;
    localparam int DEPTH_LOG2  = 4;
    localparam int DEPTH       = 16;
    localparam int BASE_CHAN   = 0;
    localparam int STATUS_CHAN = 64;
    localparam int DW          = DEPTH_LOG2 + 1;

    logic                       clk_in = 1'b0;
    logic                       reset_in;
    logic [6:0]                 chanAddr_in;
    logic [7:0]                 h2fData_in;
    logic                       h2fValid_in;
    logic                       h2fReady_out;
    logic [7:0]                 f2hData_out;
    logic                       f2hValid_out;
    logic                       f2hReady_in;
    logic [8*NUM_CHAN-1:0]      wrData_out;
    logic [NUM_CHAN-1:0]        wrValid_out;
    logic [NUM_CHAN-1:0]        wrReady_in;
    logic [8*NUM_CHAN-1:0]      rdData_in;
    logic [NUM_CHAN-1:0]        rdValid_in;
    logic [NUM_CHAN-1:0]        rdReady_out;
    logic [NUM_CHAN*DW-1:0]     wrDepth_out;
    logic [NUM_CHAN*DW-1:0]     rdDepth_out;

    int checks   = 0;
    int failures = 0;

    logic [7:0] hq [NUM_CHAN][$];
    logic [7:0] fq [NUM_CHAN][$];

    always #5 clk_in = ~clk_in;

    chan_fifo_bank #(
        .NUM_CHAN    (NUM_CHAN),
        .DEPTH_LOG2  (DEPTH_LOG2),
        .BASE_CHAN   (BASE_CHAN),
        .STATUS_CHAN (STATUS_CHAN)
    ) dut (
        .clk_in       (clk_in),
        .reset_in     (reset_in),
        .chanAddr_in  (chanAddr_in),
        .h2fData_in   (h2fData_in),
        .h2fValid_in  (h2fValid_in),
        .h2fReady_out (h2fReady_out),
        .f2hData_out  (f2hData_out),
        .f2hValid_out (f2hValid_out),
        .f2hReady_in  (f2hReady_in),
        .wrData_out   (wrData_out),
        .wrValid_out  (wrValid_out),
        .wrReady_in   (wrReady_in),
        .rdData_in    (rdData_in),
        .rdValid_in   (rdValid_in),
        .rdReady_out  (rdReady_out),
        .wrDepth_out  (wrDepth_out),
        .rdDepth_out  (rdDepth_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < NUM_CHAN; i++) begin
            hq[i].delete();
            fq[i].delete();
        end
    endtask

    task automatic checkOutputs();
        int a;
        int k;
        logic expReady;
        logic expValid;
        logic [7:0] expData;
        bit dataKnown;
        logic [NUM_CHAN-1:0] expWrValid;
        logic [NUM_CHAN-1:0] expRdReady;
        logic [8*NUM_CHAN-1:0] expWrData;
        logic [8*NUM_CHAN-1:0] mask;
        logic [NUM_CHAN*DW-1:0] expWrDepth;
        logic [NUM_CHAN*DW-1:0] expRdDepth;
        a = int'(chanAddr_in);
        expReady = 1'b1;
        expValid = 1'b1;
        expData = 8'h00;
        dataKnown = 1'b1;
        if (a >= BASE_CHAN && a < BASE_CHAN + NUM_CHAN) begin
            k = a - BASE_CHAN;
            expReady = (hq[k].size() != DEPTH);
            expValid = (fq[k].size() != 0);
            dataKnown = expValid;
            if (expValid) expData = fq[k][0];
        end
`ifdef CHAN_STATUS_EN
        else if (a >= STATUS_CHAN && a < STATUS_CHAN + 2 * NUM_CHAN) begin
            k = (a - STATUS_CHAN) / 2;
            expData = ((a - STATUS_CHAN) % 2 == 1) ? 8'(fq[k].size()) : 8'(hq[k].size());
        end
`endif
        for (int i = 0; i < NUM_CHAN; i++) begin
            expWrValid[i] = (hq[i].size() > 0);
            expRdReady[i] = (fq[i].size() < DEPTH);
            mask[i*8 +: 8] = expWrValid[i] ? 8'hFF : 8'h00;
            expWrData[i*8 +: 8] = expWrValid[i] ? hq[i][0] : 8'h00;
            expWrDepth[i*DW +: DW] = DW'(hq[i].size());
            expRdDepth[i*DW +: DW] = DW'(fq[i].size());
        end
        chk("h2fReady", h2fReady_out, expReady);
        chk("f2hValid", f2hValid_out, expValid);
        if (dataKnown) chk("f2hData", f2hData_out, expData);
        chk("wrValid", wrValid_out, expWrValid);
        chk("wrData", wrData_out & mask, expWrData);
        chk("rdReady", rdReady_out, expRdReady);
        chk("wrDepth", wrDepth_out, expWrDepth);
        chk("rdDepth", rdDepth_out, expRdDepth);
    endtask

    // Apply one clock edge of transfers to the model; decisions use pre-edge occupancy.
    task automatic modelEdge();
        bit hPop [NUM_CHAN];
        bit fPush [NUM_CHAN];
        bit hostPush;
        bit hostPop;
        int a;
        int k;
        a = int'(chanAddr_in);
        hostPush = 1'b0;
        hostPop = 1'b0;
        k = 0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            hPop[i] = wrReady_in[i] && (hq[i].size() > 0);
            fPush[i] = rdValid_in[i] && (fq[i].size() < DEPTH);
        end
        if (a >= BASE_CHAN && a < BASE_CHAN + NUM_CHAN) begin
            k = a - BASE_CHAN;
            hostPush = h2fValid_in && (hq[k].size() < DEPTH);
            hostPop = f2hReady_in && (fq[k].size() > 0);
        end
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (hPop[i]) void'(hq[i].pop_front());
            if (fPush[i]) fq[i].push_back(rdData_in[i*8 +: 8]);
        end
        if (hostPop) void'(fq[k].pop_front());
        if (hostPush) hq[k].push_back(h2fData_in);
    endtask

    // Enter and leave at posedge+1; outputs are checked mid-cycle before the edge.
    task automatic cycle();
        #3;
        checkOutputs();
        modelEdge();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        reset_in    = 1'b0;
        chanAddr_in = 7'd100;
        h2fData_in  = 8'h00;
        h2fValid_in = 1'b0;
        f2hReady_in = 1'b0;
        wrReady_in  = '0;
        rdData_in   = '0;
        rdValid_in  = '0;
        clearModel();
        #12;
        reset_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Reset state
        chanAddr_in = 7'(BASE_CHAN + 1);
        #1;
        chk("rst_h2fReady", h2fReady_out, 1'b1);
        chk("rst_wrValid", wrValid_out, '0);
        chk("rst_rdReady", rdReady_out, {NUM_CHAN{1'b1}});
        chk("rst_wrDepth", wrDepth_out, '0);
        chk("rst_rdDepth", rdDepth_out, '0);

        // 1: fill h2f ch1, overflow refused, then drain in order
        h2fValid_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            h2fData_in = 8'(i);
            cycle();
        end
        h2fData_in = 8'h10;
        chk("t1_full_ready", h2fReady_out, 1'b0);
        cycle();
        h2fValid_in = 1'b0;
        chk("t1_depth_ch1", wrDepth_out[1*DW +: DW], 5'd16);
        chk("t1_depth_ch0", wrDepth_out[0 +: DW], 5'd0);
        wrReady_in = 4'b0010;
        for (int i = 0; i < 16; i++) begin
            chk("t1_drain", wrData_out[15:8], 8'(i));
            cycle();
        end
        chk("t1_empty", wrValid_out[1], 1'b0);
        wrReady_in = '0;

        // 2: app pushes two bytes to f2h ch2, host reads them back
        chanAddr_in = 7'd100;
        rdValid_in = 4'b0100;
        rdData_in[23:16] = 8'hA5;
        cycle();
        rdData_in[23:16] = 8'h5A;
        cycle();
        rdValid_in = '0;
        chanAddr_in = 7'(BASE_CHAN + 2);
        f2hReady_in = 1'b1;
        #1;
        chk("t2_first", f2hData_out, 8'hA5);
        cycle();
        chk("t2_second", f2hData_out, 8'h5A);
        cycle();
        chk("t2_valid", f2hValid_out, 1'b0);
        chk("t2_depth", rdDepth_out[2*DW +: DW], 5'd0);
        f2hReady_in = 1'b0;

        // 3: full f2h ch0 refuses a push on the same edge as a pop
        chanAddr_in = 7'd100;
        rdValid_in = 4'b0001;
        for (int i = 0; i < 16; i++) begin
            rdData_in[7:0] = 8'(8'h30 + i);
            cycle();
        end
        chk("t3_full", rdReady_out[0], 1'b0);
        chanAddr_in = 7'(BASE_CHAN);
        f2hReady_in = 1'b1;
        rdData_in[7:0] = 8'h99;
        cycle();
        chk("t3_refused", rdDepth_out[0 +: DW], 5'd15);
        f2hReady_in = 1'b0;
        cycle();
        chk("t3_accepted", rdDepth_out[0 +: DW], 5'd16);
        rdValid_in = '0;
        f2hReady_in = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("t3_order", f2hData_out, 8'(8'h30 + i));
            cycle();
        end
        chk("t3_last", f2hData_out, 8'h99);
        cycle();
        f2hReady_in = 1'b0;

        // 4: unmapped address
        chanAddr_in = 7'd100;
        h2fValid_in = 1'b1;
        h2fData_in = 8'h77;
        f2hReady_in = 1'b1;
        #1;
        chk("t4_ready", h2fReady_out, 1'b1);
        chk("t4_valid", f2hValid_out, 1'b1);
        chk("t4_data", f2hData_out, 8'h00);
        cycle();
        chk("t4_wrDepth", wrDepth_out, '0);
        chk("t4_rdDepth", rdDepth_out, '0);
        h2fValid_in = 1'b0;
        f2hReady_in = 1'b0;

        // 5: status channels
        chanAddr_in = 7'(BASE_CHAN);
        for (int i = 0; i < 5; i++) begin
            h2fValid_in = (i < 3);
            h2fData_in = 8'(8'hE0 + i);
            rdValid_in = 4'b1000;
            rdData_in[31:24] = 8'(8'hD0 + i);
            cycle();
        end
        h2fValid_in = 1'b0;
        rdValid_in = '0;
        chanAddr_in = 7'(STATUS_CHAN);
        f2hReady_in = 1'b1;
        h2fValid_in = 1'b1;
        #1;
`ifdef CHAN_STATUS_EN
        chk("t5_stat_h2f0", f2hData_out, 8'h03);
`else
        chk("t5_stat_h2f0", f2hData_out, 8'h00);
`endif
        chk("t5_stat_valid", f2hValid_out, 1'b1);
        cycle();
        chanAddr_in = 7'(STATUS_CHAN + 7);
        #1;
`ifdef CHAN_STATUS_EN
        chk("t5_stat_f2h3", f2hData_out, 8'h05);
`else
        chk("t5_stat_f2h3", f2hData_out, 8'h00);
`endif
        cycle();
        chk("t5_no_side_fx", rdDepth_out[3*DW +: DW], 5'd5);
        h2fValid_in = 1'b0;
        f2hReady_in = 1'b0;

        // 6: asynchronous reset pulse mid-burst
        chanAddr_in = 7'(BASE_CHAN + 1);
        h2fValid_in = 1'b1;
        rdValid_in = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            h2fData_in = 8'(8'h40 + i);
            rdData_in = 32'($urandom);
            cycle();
        end
        reset_in = 1'b0;
        #1;
        clearModel();
        chk("t6_wrDepth", wrDepth_out, '0);
        chk("t6_rdDepth", rdDepth_out, '0);
        chk("t6_wrValid", wrValid_out, '0);
        chk("t6_rdReady", rdReady_out, {NUM_CHAN{1'b1}});
        reset_in = 1'b1;
        rdValid_in = '0;
        h2fData_in = 8'hC3;
        cycle();
        chk("t6_first_write", wrDepth_out[1*DW +: DW], 5'd1);
        chk("t6_first_data", wrData_out[15:8], 8'hC3);
        h2fValid_in = 1'b0;

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: chanAddr_in = 7'(BASE_CHAN + $urandom_range(0, NUM_CHAN - 1));
                6, 7:             chanAddr_in = 7'(STATUS_CHAN + $urandom_range(0, 2 * NUM_CHAN - 1));
                8:                chanAddr_in = 7'd100;
                default:          chanAddr_in = 7'($urandom_range(0, 127));
            endcase
            h2fData_in  = 8'($urandom);
            h2fValid_in = ($urandom_range(0, 3) != 0);
            f2hReady_in = ($urandom_range(0, 2) == 0);
            wrReady_in  = 4'($urandom) & 4'($urandom);
            rdValid_in  = 4'($urandom) | 4'($urandom);
            rdData_in   = 32'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
